io_mem_arbiter: RTL and testbench
=================================

Name: io_mem_arbiter

Overview:
- Sits between the MIX CPU and up to N character I/O units (card reader, tape, printer, and similar).
- Dispatches IN/OUT start pulses from the CPU to the addressed unit and returns that unit's stop to the CPU.
- Shares the single memory write port among the units' word-store requests using round-robin arbitration.
- Each unit keeps its existing handshake: it raises request with its address and word, the arbiter pulses store, and the unit drops request on the next edge.

Parameters:
N, 4, number of attached I/O units (2..8)
UW, 3, unit-number width; must satisfy 2**UW >= N
AW, 12, memory address width
WW, 30, MIX word width (5 bytes x 6 bits, no sign)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cpu_start  in  1  one-cycle pulse: CPU issues an I/O instruction
cpu_unit  in  UW  target unit number, sampled with cpu_start
cpu_addr  in  AW  buffer start address, sampled with cpu_start
cpu_stop  out  1  one-cycle pulse: CPU may resume
bad_unit  out  1  one-cycle pulse: cpu_unit >= N
unit_busy  out  1  busy[cpu_unit], combinational (for JBUS/JRED); 0 if cpu_unit >= N
start  out  N  one-hot start pulse per unit
addressin  out  AW  registered copy of cpu_addr, broadcast to all units
busy  in  N  per-unit busy
stop  in  N  per-unit stop pulse
request  in  N  per-unit store request (level)
addressout  in  N*AW  per-unit target addresses; unit i at [i*AW +: AW]
out  in  N*WW  per-unit data words; unit i at [i*WW +: WW]
store  out  N  one-hot, one-cycle grant/store pulse
mem_we  out  1  memory write enable
mem_addr  out  AW  memory write address
mem_data  out  WW  memory write data

Behaviour:
Reset values:
- All outputs 0.
- Dispatch FSM in D_IDLE; arbitration FSM in A_IDLE.
- Round-robin pointer rr = 0.

Dispatch FSM (D_IDLE, D_WAIT):
- D_IDLE, cpu_start, cpu_unit < N:
  - Next edge: start[cpu_unit] = 1 for one cycle; addressin <= cpu_addr (held until the next dispatch); latch cur_unit.
  - Go to D_WAIT.
- D_IDLE, cpu_start, cpu_unit >= N:
  - Next edge: bad_unit = 1 and cpu_stop = 1, both for one cycle.
  - Stay in D_IDLE; no start issued.
- D_WAIT:
  - When stop[cur_unit] = 1: cpu_stop = 1 on the next edge for one cycle, then D_IDLE. Latency is 1 cycle from unit stop to cpu_stop.
  - stop from any other unit is ignored.
  - cpu_start in D_WAIT is ignored; the CPU is stalled by protocol.
- A unit that is already busy is still started. The unit itself handles its own queueing (start2) and delays its stop.

Arbitration FSM (A_IDLE, A_WRITE, A_GAP):
- A_IDLE, any request bit set:
  - Winner w = first set bit scanning rr, rr+1, ..., N-1, 0, ..., wrapping modulo N.
  - Next edge: go to A_WRITE; store[w] = 1; mem_we = 1; mem_addr = addressout[w]; mem_data = out[w]. All are registered, so they are valid together for exactly one cycle.
  - rr <= (w + 1) mod N.
- A_WRITE: always go to A_GAP next edge. store and mem_we deassert.
- A_GAP: one dead cycle so the granted unit's request can clear; then A_IDLE.
- Throughput: at most one word per 3 cycles across all units. A unit's byte rate is far below this, so no unit starves.
- Simultaneous requests: exactly one store bit per grant. rr guarantees each requester is granted within N grants.
- A request that drops before being granted is simply not served; no state is kept.
- The dispatch and arbitration FSMs are independent. cpu_start and a grant in the same cycle are both honoured.
- mem_addr and mem_data hold their last values when mem_we = 0.

Reset mid-operation:
- Asynchronous reset clears both FSMs, rr and all pulses immediately.
- A write in flight is dropped: mem_we falls at reset assertion.
- Units are reset by the same signal.

Test Plan:
1. Reset while A_WRITE with mem_we=1 -> mem_we, store, cpu_stop drop asynchronously (before the next clk edge); after release rr=0 and both FSMs idle.
2. cpu_start, cpu_unit=1, cpu_addr=12'd100 -> start=4'b0010 for one cycle on the next edge, addressin=100. Pulse stop[1] 20 cycles later -> cpu_stop pulse exactly 1 cycle after. Pulsing stop[2] instead -> no cpu_stop.
3. cpu_start, cpu_unit=5 with N=4 -> bad_unit and cpu_stop pulse together; start stays 0; dispatch FSM stays D_IDLE.
4. request=4'b1111 held, each unit dropping request on its store pulse -> grants in order unit 0,1,2,3, 3 cycles apart. mem_addr/mem_data match each unit's addressout/out; each store is one-hot and 1 cycle wide.
5. request[2] held continuously, request[0] raised once rr=3 -> next grants go to 0 then 2 (wrap-around fairness). Unit 2 is never granted twice in a row while unit 0 waits.
6. cpu_start to unit 0 in the same cycle that request[3] is granted -> start[0] and store[3] both pulse on the same edge; mem_addr = addressout[3]; no interaction.

Source files
------------

// File: rtl/io_mem_arbiter_if.sv
// io_mem_arbiter_if
//   Bundles every signal between the MIX CPU, the character I/O units and the
//   memory write port into one interface.
//   master : the arbiter side (drives start/store/memory write, cpu_stop).
//   slave  : the CPU, the units and the memory (drive requests, stops, data).
//
//   CPU side    : cpu_start, cpu_unit, cpu_addr -> ; <- cpu_stop, bad_unit, unit_busy
//   Unit side   : busy, stop, request, addressout, out -> ; <- start, addressin, store
//   Memory side : <- mem_we, mem_addr, mem_data
interface io_mem_arbiter_if #(
  parameter int N  = 4,
  parameter int UW = 3,
  parameter int AW = 12,
  parameter int WW = 30
);
  logic            cpu_start;
  logic [UW-1:0]   cpu_unit;
  logic [AW-1:0]   cpu_addr;
  logic            cpu_stop;
  logic            bad_unit;
  logic            unit_busy;
  logic [N-1:0]    start;
  logic [AW-1:0]   addressin;
  logic [N-1:0]    busy;
  logic [N-1:0]    stop;
  logic [N-1:0]    request;
  logic [N*AW-1:0] addressout;
  logic [N*WW-1:0] out;
  logic [N-1:0]    store;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [WW-1:0]   mem_data;

  modport master (
    input  cpu_start, cpu_unit, cpu_addr, busy, stop, request, addressout, out,
    output cpu_stop, bad_unit, unit_busy, start, addressin, store,
           mem_we, mem_addr, mem_data
  );

  modport slave (
    output cpu_start, cpu_unit, cpu_addr, busy, stop, request, addressout, out,
    input  cpu_stop, bad_unit, unit_busy, start, addressin, store,
           mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/io_mem_arbiter.sv
// io_mem_arbiter
//   Connects the MIX CPU to up to N character I/O units.
//   - Dispatch FSM: forwards an IN/OUT start pulse to the addressed unit and
//     returns that unit's stop to the CPU one cycle later. An out-of-range unit
//     number gets an immediate bad_unit + cpu_stop pulse instead.
//   - Arbitration FSM: shares the single memory write port among the units'
//     store requests, round-robin, one word per three cycles at most.
//
//   Ports:
//     clk    : system clock
//     reset  : asynchronous, active-high reset
//     arb_if : io_mem_arbiter_if.master (CPU, unit and memory signals)
module io_mem_arbiter #(
  parameter int N  = 4,
  parameter int UW = 3,
  parameter int AW = 12,
  parameter int WW = 30
) (
  input logic               clk,
  input logic               reset,
  io_mem_arbiter_if.master  arb_if
);

  typedef enum logic {D_IDLE, D_WAIT} dispState_t;
  typedef enum logic [1:0] {A_IDLE, A_WRITE, A_GAP} arbState_t;

  dispState_t      dispState_q, dispState_d;
  logic [UW-1:0]   curUnit_q, curUnit_d;
  logic [N-1:0]    start_q, start_d;
  logic [AW-1:0]   addressIn_q, addressIn_d;
  logic            cpuStop_q, cpuStop_d;
  logic            badUnit_q, badUnit_d;

  arbState_t       arbState_q, arbState_d;
  logic [UW-1:0]   rrPtr_q, rrPtr_d;
  logic [N-1:0]    store_q, store_d;
  logic            memWe_q, memWe_d;
  logic [AW-1:0]   memAddr_q, memAddr_d;
  logic [WW-1:0]   memData_q, memData_d;

  logic            cpuUnitValid;
  logic            unitBusy;
  logic            stopCur;
  logic            reqFound;
  logic [UW-1:0]   winIdx;

  // Extend by one bit so the range check also works when N == 2**UW.
  assign cpuUnitValid = ({1'b0, arb_if.cpu_unit} < (UW+1)'(N));

  // Decoded per-unit selects; loops avoid indexing past N with a UW-bit index.
  always_comb begin : unitSelects
    unitBusy = 1'b0;
    stopCur  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (arb_if.cpu_unit == UW'(i)) unitBusy = arb_if.busy[i];
      if (curUnit_q == UW'(i))       stopCur  = arb_if.stop[i];
    end
  end

  // ---------------- Dispatch FSM ----------------

  always_ff @(posedge clk or posedge reset) begin : dispRegs
    if (reset) begin
      dispState_q <= D_IDLE;
      curUnit_q   <= '0;
      start_q     <= '0;
      addressIn_q <= '0;
      cpuStop_q   <= 1'b0;
      badUnit_q   <= 1'b0;
    end else begin
      dispState_q <= dispState_d;
      curUnit_q   <= curUnit_d;
      start_q     <= start_d;
      addressIn_q <= addressIn_d;
      cpuStop_q   <= cpuStop_d;
      badUnit_q   <= badUnit_d;
    end
  end

  always_comb begin : dispNext
    dispState_d = dispState_q;
    case (dispState_q)
      D_IDLE:  if (arb_if.cpu_start && cpuUnitValid) dispState_d = D_WAIT;
      D_WAIT:  if (stopCur) dispState_d = D_IDLE;
      default: dispState_d = D_IDLE;
    endcase
  end

  // cpu_start while waiting is ignored: the CPU is stalled until cpu_stop.
  always_comb begin : dispOutputs
    start_d     = '0;
    cpuStop_d   = 1'b0;
    badUnit_d   = 1'b0;
    addressIn_d = addressIn_q;
    curUnit_d   = curUnit_q;
    case (dispState_q)
      D_IDLE: begin
        if (arb_if.cpu_start) begin
          if (cpuUnitValid) begin
            for (int i = 0; i < N; i++) begin
              if (arb_if.cpu_unit == UW'(i)) start_d[i] = 1'b1;
            end
            addressIn_d = arb_if.cpu_addr;
            curUnit_d   = arb_if.cpu_unit;
          end else begin
            badUnit_d = 1'b1;
            cpuStop_d = 1'b1;
          end
        end
      end
      D_WAIT:  if (stopCur) cpuStop_d = 1'b1;
      default: ;
    endcase
  end

  // ---------------- Arbitration FSM ----------------

  // Round-robin winner: first request found scanning rr, rr+1, ... mod N.
  always_comb begin : arbWinner
    reqFound = 1'b0;
    winIdx   = '0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!reqFound && arb_if.request[i] && (i == ((int'(rrPtr_q) + k) % N))) begin
          reqFound = 1'b1;
          winIdx   = UW'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin : arbRegs
    if (reset) begin
      arbState_q <= A_IDLE;
      rrPtr_q    <= '0;
      store_q    <= '0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memData_q  <= '0;
    end else begin
      arbState_q <= arbState_d;
      rrPtr_q    <= rrPtr_d;
      store_q    <= store_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memData_q  <= memData_d;
    end
  end

  // A_GAP gives the granted unit one edge to drop its request before rescanning.
  always_comb begin : arbNext
    arbState_d = arbState_q;
    case (arbState_q)
      A_IDLE:  if (reqFound) arbState_d = A_WRITE;
      A_WRITE: arbState_d = A_GAP;
      A_GAP:   arbState_d = A_IDLE;
      default: arbState_d = A_IDLE;
    endcase
  end

  // Memory address/data hold their last values whenever mem_we is low.
  always_comb begin : arbOutputs
    store_d   = '0;
    memWe_d   = 1'b0;
    memAddr_d = memAddr_q;
    memData_d = memData_q;
    rrPtr_d   = rrPtr_q;
    if (arbState_q == A_IDLE && reqFound) begin
      memWe_d = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (winIdx == UW'(i)) begin
          store_d[i] = 1'b1;
          memAddr_d  = arb_if.addressout[i*AW +: AW];
          memData_d  = arb_if.out[i*WW +: WW];
        end
      end
      rrPtr_d = (winIdx == UW'(N-1)) ? '0 : winIdx + 1'b1;
    end
  end

  assign arb_if.start     = start_q;
  assign arb_if.addressin = addressIn_q;
  assign arb_if.cpu_stop  = cpuStop_q;
  assign arb_if.bad_unit  = badUnit_q;
  assign arb_if.unit_busy = unitBusy;
  assign arb_if.store     = store_q;
  assign arb_if.mem_we    = memWe_q;
  assign arb_if.mem_addr  = memAddr_q;
  assign arb_if.mem_data  = memData_q;

endmodule

// File: tb/tb_io_mem_arbiter.sv
// tb_io_mem_arbiter
//   Directed bench for io_mem_arbiter with N=4, UW=3, AW=12, WW=30.
//   A table of per-cycle dispatch vectors plus hand-written sequences for
//   round-robin ordering, wrap-around fairness, concurrent dispatch/grant
//   and asynchronous reset during a memory write.
module tb_io_mem_arbiter;

  localparam int N  = 4;
  localparam int UW = 3;
  localparam int AW = 12;
  localparam int WW = 30;
  localparam int NVEC = 12;

  logic clk;
  logic reset;
  int   totalChecks;
  int   badChecks;

  io_mem_arbiter_if #(.N(N), .UW(UW), .AW(AW), .WW(WW)) arbIf ();

  io_mem_arbiter #(.N(N), .UW(UW), .AW(AW), .WW(WW)) dut (
    .clk    (clk),
    .reset  (reset),
    .arb_if (arbIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          cpuStart;
    logic [UW-1:0] cpuUnit;
    logic [AW-1:0] cpuAddr;
    logic [N-1:0]  stopIn;
    logic [N-1:0]  busyIn;
    logic          expUnitBusy;
    logic [N-1:0]  expStart;
    logic          expCpuStop;
    logic          expBadUnit;
    logic [AW-1:0] expAddrIn;
  } vecT;

  vecT vecs [NVEC];

  // Unit i stores at address 10*(i+1) with data word 1000+i.
  function automatic logic [AW-1:0] unitAddr(input int i);
    return AW'(10 * (i + 1));
  endfunction

  function automatic logic [WW-1:0] unitData(input int i);
    return WW'(1000 + i);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic cs, input logic [UW-1:0] cu,
                               input logic [AW-1:0] ca, input logic [N-1:0] st,
                               input logic [N-1:0] bz, input logic [N-1:0] rq);
    arbIf.cpu_start = cs;
    arbIf.cpu_unit  = cu;
    arbIf.cpu_addr  = ca;
    arbIf.stop      = st;
    arbIf.busy      = bz;
    arbIf.request   = rq;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    reset       = 1'b1;
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    for (int i = 0; i < N; i++) begin
      arbIf.addressout[i*AW +: AW] = unitAddr(i);
      arbIf.out[i*WW +: WW]        = unitData(i);
    end

    //             start unit  addr      stop     busy     ub    start    cstop bad  addrin
    vecs[0]  = '{1'b1, 3'd1, 12'd100,  4'b0000, 4'b0010, 1'b1, 4'b0010, 1'b0, 1'b0, 12'd100};
    vecs[1]  = '{1'b0, 3'd1, 12'd0,    4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 12'd100};
    vecs[2]  = '{1'b1, 3'd3, 12'd7,    4'b0000, 4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0, 12'd100};
    vecs[3]  = '{1'b0, 3'd0, 12'd0,    4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 12'd100};
    vecs[4]  = '{1'b0, 3'd0, 12'd0,    4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 12'd100};
    vecs[5]  = '{1'b1, 3'd5, 12'd55,   4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 12'd100};
    vecs[6]  = '{1'b1, 3'd0, 12'd200,  4'b0000, 4'b0001, 1'b1, 4'b0001, 1'b0, 1'b0, 12'd200};
    vecs[7]  = '{1'b0, 3'd0, 12'd0,    4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 12'd200};
    vecs[8]  = '{1'b1, 3'd7, 12'd9,    4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 12'd200};
    vecs[9]  = '{1'b1, 3'd3, 12'd4095, 4'b0000, 4'b1000, 1'b1, 4'b1000, 1'b0, 1'b0, 12'd4095};
    vecs[10] = '{1'b0, 3'd3, 12'd0,    4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b1, 1'b0, 12'd4095};
    vecs[11] = '{1'b0, 3'd0, 12'd0,    4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 12'd4095};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_start",     64'(arbIf.start),     64'h0);
    checkOutput("rst_store",     64'(arbIf.store),     64'h0);
    checkOutput("rst_mem_we",    64'(arbIf.mem_we),    64'h0);
    checkOutput("rst_mem_addr",  64'(arbIf.mem_addr),  64'h0);
    checkOutput("rst_mem_data",  64'(arbIf.mem_data),  64'h0);
    checkOutput("rst_cpu_stop",  64'(arbIf.cpu_stop),  64'h0);
    checkOutput("rst_bad_unit",  64'(arbIf.bad_unit),  64'h0);
    checkOutput("rst_addressin", 64'(arbIf.addressin), 64'h0);
    checkOutput("rst_unit_busy", 64'(arbIf.unit_busy), 64'h0);
    reset = 1'b0;

    // Dispatch vector table
    for (int v = 0; v < NVEC; v++) begin
      applyStimulus(vecs[v].cpuStart, vecs[v].cpuUnit, vecs[v].cpuAddr,
                    vecs[v].stopIn, vecs[v].busyIn, '0);
      #1;
      checkOutput($sformatf("vec%0d_unit_busy", v), 64'(arbIf.unit_busy), 64'(vecs[v].expUnitBusy));
      tick();
      checkOutput($sformatf("vec%0d_start", v),     64'(arbIf.start),     64'(vecs[v].expStart));
      checkOutput($sformatf("vec%0d_cpu_stop", v),  64'(arbIf.cpu_stop),  64'(vecs[v].expCpuStop));
      checkOutput($sformatf("vec%0d_bad_unit", v),  64'(arbIf.bad_unit),  64'(vecs[v].expBadUnit));
      checkOutput($sformatf("vec%0d_addressin", v), 64'(arbIf.addressin), 64'(vecs[v].expAddrIn));
      checkOutput($sformatf("vec%0d_mem_we", v),    64'(arbIf.mem_we),    64'h0);
    end

    // Long wait for the addressed unit; foreign stop ignored, own stop returned
    applyStimulus(1'b1, 3'd1, 12'd100, '0, '0, '0);
    tick();
    checkOutput("seq2_start", 64'(arbIf.start), 64'b0010);
    checkOutput("seq2_addressin", 64'(arbIf.addressin), 64'd100);
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    tick();
    checkOutput("seq2_start_width", 64'(arbIf.start), 64'h0);
    for (int c = 0; c < 19; c++) begin
      tick();
      checkOutput("seq2_idle_cpu_stop", 64'(arbIf.cpu_stop), 64'h0);
    end
    applyStimulus(1'b0, '0, '0, 4'b0100, '0, '0);
    tick();
    checkOutput("seq2_foreign_stop", 64'(arbIf.cpu_stop), 64'h0);
    applyStimulus(1'b0, '0, '0, 4'b0010, '0, '0);
    tick();
    checkOutput("seq2_cpu_stop", 64'(arbIf.cpu_stop), 64'h1);
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    tick();
    checkOutput("seq2_cpu_stop_width", 64'(arbIf.cpu_stop), 64'h0);

    // All four units request: grants 0,1,2,3, three cycles apart
    arbIf.request = 4'b1111;
    for (int g = 0; g < N; g++) begin
      tick();
      checkOutput($sformatf("rr%0d_store", g),    64'(arbIf.store),    64'(4'b0001 << g));
      checkOutput($sformatf("rr%0d_mem_we", g),   64'(arbIf.mem_we),   64'h1);
      checkOutput($sformatf("rr%0d_mem_addr", g), 64'(arbIf.mem_addr), 64'(unitAddr(g)));
      checkOutput($sformatf("rr%0d_mem_data", g), 64'(arbIf.mem_data), 64'(unitData(g)));
      arbIf.request[g] = 1'b0;
      tick();
      checkOutput($sformatf("rr%0d_store_off", g), 64'(arbIf.store),    64'h0);
      checkOutput($sformatf("rr%0d_we_off", g),    64'(arbIf.mem_we),   64'h0);
      checkOutput($sformatf("rr%0d_addr_hold", g), 64'(arbIf.mem_addr), 64'(unitAddr(g)));
      tick();
      checkOutput($sformatf("rr%0d_gap_store", g), 64'(arbIf.store),    64'h0);
    end

    // Wrap-around fairness: unit 2 holds, unit 0 raised once rr = 3
    arbIf.request = 4'b0100;
    tick();
    checkOutput("wrap_first_store", 64'(arbIf.store), 64'b0100);
    arbIf.request = 4'b0101;
    tick();
    tick();
    tick();
    checkOutput("wrap_unit0_store", 64'(arbIf.store),    64'b0001);
    checkOutput("wrap_unit0_addr",  64'(arbIf.mem_addr), 64'(unitAddr(0)));
    checkOutput("wrap_unit0_data",  64'(arbIf.mem_data), 64'(unitData(0)));
    arbIf.request = 4'b0100;
    tick();
    tick();
    tick();
    checkOutput("wrap_unit2_store", 64'(arbIf.store),    64'b0100);
    checkOutput("wrap_unit2_addr",  64'(arbIf.mem_addr), 64'(unitAddr(2)));
    arbIf.request = 4'b0000;
    tick();
    tick();

    // Dispatch to unit 0 and grant to unit 3 on the same edge (rr = 3 here)
    applyStimulus(1'b1, 3'd0, 12'd321, '0, '0, 4'b1000);
    tick();
    checkOutput("conc_start",     64'(arbIf.start),     64'b0001);
    checkOutput("conc_store",     64'(arbIf.store),     64'b1000);
    checkOutput("conc_mem_addr",  64'(arbIf.mem_addr),  64'(unitAddr(3)));
    checkOutput("conc_addressin", 64'(arbIf.addressin), 64'd321);
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    tick();
    tick();
    applyStimulus(1'b0, '0, '0, 4'b0001, '0, '0);
    tick();
    checkOutput("conc_cpu_stop", 64'(arbIf.cpu_stop), 64'h1);
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    tick();

    // Asynchronous reset while a write and a cpu_stop pulse are live (rr = 0)
    applyStimulus(1'b1, 3'd6, 12'd0, '0, '0, 4'b0010);
    tick();
    checkOutput("ar_pre_mem_we",   64'(arbIf.mem_we),   64'h1);
    checkOutput("ar_pre_store",    64'(arbIf.store),    64'b0010);
    checkOutput("ar_pre_cpu_stop", 64'(arbIf.cpu_stop), 64'h1);
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    reset = 1'b1;
    #1;
    checkOutput("ar_mem_we",    64'(arbIf.mem_we),    64'h0);
    checkOutput("ar_store",     64'(arbIf.store),     64'h0);
    checkOutput("ar_cpu_stop",  64'(arbIf.cpu_stop),  64'h0);
    checkOutput("ar_bad_unit",  64'(arbIf.bad_unit),  64'h0);
    checkOutput("ar_addressin", 64'(arbIf.addressin), 64'h0);
    #2;
    reset = 1'b0;
    applyStimulus(1'b1, 3'd2, 12'd77, '0, '0, 4'b1111);
    tick();
    checkOutput("ar_rr_zero_store", 64'(arbIf.store),     64'b0001);
    checkOutput("ar_disp_idle",     64'(arbIf.start),     64'b0100);
    checkOutput("ar_addressin_new", 64'(arbIf.addressin), 64'd77);
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    tick();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
